// File: rtl/apb_reg_bridge.sv
// APB4 slave bridge to a word-addressed register set: one transfer in flight,
// registered register-side request, PSLVERR on out-of-range index or done timeout.
module apb_reg_bridge #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int REG_DEPTH = 16,
  parameter int TIMEOUT   = 15,
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic              s_apb_pclk_i,
  input  logic              s_apb_preset_i,
  input  logic              s_apb_psel_i,
  input  logic              s_apb_penable_i,
  input  logic [ADDR_W-1:0] s_apb_paddr_i,
  input  logic              s_apb_pwrite_i,
  input  logic [DATA_W-1:0] s_apb_pwdata_i,
  input  logic [STRB_W-1:0] s_apb_pstrb_i,
  output logic [DATA_W-1:0] s_apb_prdata_o,
  output logic              s_apb_pready_o,
  output logic              s_apb_pslverr_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_data_o,
  output logic [STRB_W-1:0] reg_strb_o,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic              reg_wr_en_o,
  output logic              reg_rd_en_o,
  input  logic              reg_wr_done_i,
  input  logic              reg_rd_done_i,
  output logic              timeout_o
);

  localparam int OFF   = $clog2(STRB_W);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                to_q, to_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic                timeout_q, timeout_d;

  logic [ADDR_W-1:0]   idx;
  logic                done;

  assign idx  = s_apb_paddr_i >> OFF;
  assign done = write_q ? reg_wr_done_i : reg_rd_done_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    to_d      = to_q;
    write_d   = write_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        // pready_q still high means the access phase just completed; not a new request
        if (s_apb_psel_i && s_apb_penable_i && !pready_q) begin
          addr_d  = idx;
          data_d  = s_apb_pwdata_i;
          strb_d  = s_apb_pwrite_i ? s_apb_pstrb_i : '0;
          write_d = s_apb_pwrite_i;
          to_d    = 1'b0;
          if (32'(idx) >= 32'(REG_DEPTH)) begin
            err_d   = 1'b1;
            state_d = RESP;
            if (!s_apb_pwrite_i) prdata_d = '0;
          end else begin
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        wr_en_d = write_q;
        rd_en_d = !write_q;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done) begin
          if (!write_q) prdata_d = reg_data_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          if (!write_q) prdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        pready_d  = 1'b1;
        pslverr_d = err_q;
        timeout_d = to_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_apb_pclk_i or posedge s_apb_preset_i) begin
    if (s_apb_preset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      to_q      <= to_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      timeout_q <= timeout_d;
    end
  end

  assign s_apb_prdata_o  = prdata_q;
  assign s_apb_pready_o  = pready_q;
  assign s_apb_pslverr_o = pslverr_q;
  assign reg_addr_o      = addr_q;
  assign reg_data_o      = data_q;
  assign reg_strb_o      = strb_q;
  assign reg_wr_en_o     = wr_en_q;
  assign reg_rd_en_o     = rd_en_q;
  assign timeout_o       = timeout_q;

endmodule
